// File: rtl/mips_ram_1r1w.sv
// Byte-wide RAM with one combinational read port and one synchronous write port.
// Contents are deliberately not reset so a program image survives a core reset.
module mips_ram_1r1w #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_boot_memory.sv
// External memory for the 8-bit multicycle mips core: streams a boot image into RAM
// while holding the core in reset, then serves the core bus with one memory-mapped output port.
module mips_boot_memory #(
  parameter int            AW       = 8,
  parameter int            BOOT_LEN = 64,
  parameter logic [AW-1:0] IO_ADDR  = AW'(8'hFF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    boot_data,
  input  logic          boot_valid,
  output logic          boot_ready,
  output logic          boot_done,
  output logic          cpu_reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] adr,
  input  logic [7:0]    writedata,
  output logic [7:0]    memdata,
  output logic [7:0]    io_out,
  output logic          io_strobe
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [AW:0] LAST_PTR = (AW+1)'(BOOT_LEN - 1);

  generate
    if (BOOT_LEN < 1 || BOOT_LEN > 2**AW) begin : g_bad_boot_len
      $error("mips_boot_memory: BOOT_LEN must be in 1..2**AW");
    end
  endgenerate

  state_t      state_q, state_d;
  logic [AW:0] ptr_q, ptr_d;
  logic [7:0]  io_out_q, io_out_d;
  logic        io_strobe_q, io_strobe_d;
  logic        cpu_reset_q, cpu_reset_d;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
  logic          io_hit;

  assign io_hit = (adr == IO_ADDR);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    io_out_d    = io_out_q;
    io_strobe_d = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = adr;
    ram_wdata   = writedata;
    memdata     = 8'h00;

    unique case (state_q)
      LOAD: begin
        // Loader owns the write port; core writes are dropped entirely.
        ram_waddr = ptr_q[AW-1:0];
        ram_wdata = boot_data;
        if (boot_valid) begin
          ram_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          if (ptr_q == LAST_PTR) state_d = START;
        end
      end
      START: begin
        state_d = RUN;
      end
      RUN: begin
        memdata = io_hit ? io_out_q : ram_rdata;
        if (memwrite) begin
          if (io_hit) begin
            io_out_d    = writedata;
            io_strobe_d = 1'b1;
          end else begin
            ram_we = 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    // Registered so the core sees a glitch-free reset that drops on the edge entering RUN.
    cpu_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      ptr_q       <= '0;
      io_out_q    <= 8'h00;
      io_strobe_q <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      io_out_q    <= io_out_d;
      io_strobe_q <= io_strobe_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  mips_ram_1r1w #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (adr),
    .rdata (ram_rdata)
  );

  assign boot_ready = (state_q == LOAD);
  assign boot_done  = (state_q == RUN);
  assign cpu_reset  = cpu_reset_q;
  assign io_out     = io_out_q;
  assign io_strobe  = io_strobe_q;

  // memread is implied: read data is always driven in RUN.
  logic unused_memread;
  assign unused_memread = memread;

endmodule

// File: tb/tb_mips_boot_memory.sv
// Directed bench for mips_boot_memory with BOOT_LEN=4: boot handshake, core bus, IO port, reset behaviour.
module tb_mips_boot_memory;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] boot_data;
  logic       boot_valid;
  logic       boot_ready, boot_done, cpu_reset;
  logic       memread, memwrite;
  logic [7:0] adr, writedata, memdata, io_out;
  logic       io_strobe;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_boot_memory #(.AW(8), .BOOT_LEN(4), .IO_ADDR(8'hFF)) dut (
    .clk        (clk),
    .reset      (reset),
    .boot_data  (boot_data),
    .boot_valid (boot_valid),
    .boot_ready (boot_ready),
    .boot_done  (boot_done),
    .cpu_reset  (cpu_reset),
    .memread    (memread),
    .memwrite   (memwrite),
    .adr        (adr),
    .writedata  (writedata),
    .memdata    (memdata),
    .io_out     (io_out),
    .io_strobe  (io_strobe)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp_v);
    adr = a;
    #1;
    check(tag, {24'h0, memdata}, {24'h0, exp_v});
  endtask

  task automatic core_write(input logic [7:0] a, input logic [7:0] d);
    memwrite  = 1'b1;
    adr       = a;
    writedata = d;
    tick();
    memwrite  = 1'b0;
  endtask

  // Streams four bytes; gap inserts an idle cycle before each byte. Checks the release timing.
  task automatic load4(input string tag, input logic [7:0] b [4], input bit gap);
    for (int i = 0; i < 4; i++) begin
      if (gap) begin
        boot_valid = 1'b0;
        tick();
      end
      boot_data  = b[i];
      boot_valid = 1'b1;
      tick();
      if (i == 2) begin
        check({tag, " ready_before_last"}, {31'h0, boot_ready}, 32'h1);
        check({tag, " cpu_reset_mid"}, {31'h0, cpu_reset}, 32'h1);
      end
    end
    boot_valid = 1'b0;
    check({tag, " ready_low_after_last"}, {31'h0, boot_ready}, 32'h0);
    check({tag, " cpu_reset_in_start"}, {31'h0, cpu_reset}, 32'h1);
    tick();
    check({tag, " cpu_reset_released"}, {31'h0, cpu_reset}, 32'h0);
    check({tag, " boot_done"}, {31'h0, boot_done}, 32'h1);
  endtask

  logic [7:0] img_a [4];
  logic [7:0] img_b [4];

  initial begin
    img_a = '{8'h43, 8'h12, 8'hA0, 8'hFF};
    img_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset = 1'b1; boot_data = 8'h00; boot_valid = 1'b0;
    memread = 1'b0; memwrite = 1'b0; adr = 8'h00; writedata = 8'h00;
    tick(); tick();
    check("rst cpu_reset", {31'h0, cpu_reset}, 32'h1);
    check("rst boot_ready", {31'h0, boot_ready}, 32'h1);
    check("rst boot_done", {31'h0, boot_done}, 32'h0);
    check("rst io_out", {24'h0, io_out}, 32'h0);
    check("rst io_strobe", {31'h0, io_strobe}, 32'h0);
    reset = 1'b0;
    tick();
    read_chk("load memdata zero", 8'h00, 8'h00);

    // Test 1: contiguous stream.
    load4("t1", img_a, 1'b0);
    for (int i = 0; i < 4; i++) read_chk($sformatf("t1 rd%0d", i), 8'(i), img_a[i]);

    // Tests 2 and 6: gapped stream, with a core write injected during LOAD.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    boot_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      boot_valid = 1'b0; tick();
      boot_data = img_a[i]; boot_valid = 1'b1; tick();
    end
    boot_valid = 1'b0;
    core_write(8'h02, 8'hEE);
    check("t6 ready_unaffected", {31'h0, boot_ready}, 32'h1);
    check("t2 still_loading", {31'h0, cpu_reset}, 32'h1);
    boot_data = img_a[3]; boot_valid = 1'b1; tick();
    boot_valid = 1'b0;
    check("t2 ready_low", {31'h0, boot_ready}, 32'h0);
    check("t2 cpu_reset_start", {31'h0, cpu_reset}, 32'h1);
    tick();
    check("t2 cpu_reset_run", {31'h0, cpu_reset}, 32'h0);
    for (int i = 0; i < 4; i++) read_chk($sformatf("t2 rd%0d", i), 8'(i), img_a[i]);

    // Test 3: RAM write/read, neighbour untouched, read-before-write.
    core_write(8'h11, 8'h5A);
    core_write(8'h10, 8'hA5);
    read_chk("t3 rd10", 8'h10, 8'hA5);
    read_chk("t3 rd11", 8'h11, 8'h5A);
    memwrite = 1'b1; writedata = 8'h77;
    read_chk("t3 rbw old", 8'h10, 8'hA5);
    tick(); memwrite = 1'b0;
    read_chk("t3 rbw new", 8'h10, 8'h77);
    boot_data = 8'h99; boot_valid = 1'b1; tick(); boot_valid = 1'b0;
    read_chk("t3 boot ignored", 8'h00, 8'h43);

    // Test 4: IO port write, strobe width, back-to-back strobes.
    check("t4 strobe idle", {31'h0, io_strobe}, 32'h0);
    core_write(8'hFF, 8'h3C);
    check("t4 io_out", {24'h0, io_out}, 32'h3C);
    check("t4 strobe hi", {31'h0, io_strobe}, 32'h1);
    read_chk("t4 rdFF", 8'hFF, 8'h3C);
    tick();
    check("t4 strobe lo", {31'h0, io_strobe}, 32'h0);
    read_chk("t4 rd10 intact", 8'h10, 8'h77);
    memwrite = 1'b1; adr = 8'hFF; writedata = 8'h01; tick();
    check("t4 b2b io1", {24'h0, io_out}, 32'h01);
    writedata = 8'h02; tick(); memwrite = 1'b0;
    check("t4 b2b strobe", {31'h0, io_strobe}, 32'h1);
    check("t4 b2b io2", {24'h0, io_out}, 32'h02);
    tick();
    check("t4 b2b strobe end", {31'h0, io_strobe}, 32'h0);

    // Test 5: async reset from RUN, partial load, reset again, full reload.
    reset = 1'b1; #1;
    check("t5 async cpu_reset", {31'h0, cpu_reset}, 32'h1);
    check("t5 async io_out", {24'h0, io_out}, 32'h0);
    tick(); reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      boot_data = 8'hA0 + 8'(i); boot_valid = 1'b1; tick();
    end
    boot_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    load4("t5", img_b, 1'b0);
    for (int i = 0; i < 4; i++) read_chk($sformatf("t5 rd%0d", i), 8'(i), img_b[i]);
    read_chk("t5 ram survives", 8'h11, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
